// File: rtl/video_seq_pkg.sv
// Shared types and widths for the video output start sequencer.
// State encoding, counter widths and a saturating increment helper.
package video_seq_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        WAIT_FRAME = 2'd1,
        FILL       = 2'd2,
        RUN        = 2'd3
    } state_e;

    localparam int HOLD_CNT_W = 8;
    localparam int FILL_CNT_W = 4;
    localparam int WDT_CNT_W  = 24;
    localparam int RESYNC_W   = 8;

    function automatic logic [RESYNC_W-1:0] sat_inc(
        input logic [RESYNC_W-1:0] v
    );
        return (&v) ? v : v + RESYNC_W'(1);
    endfunction

endpackage

// File: rtl/video_seq_watchdog.sv
// Input frame-start watchdog for the output start sequencer.
// Counts enabled cycles since the last clear; flags expiry at WDT_CYCLES-1.
module video_seq_watchdog
    import video_seq_pkg::*;
#(
    parameter logic [WDT_CNT_W-1:0] WDT_CYCLES = 24'd2_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WDT_CNT_W-1:0] WdtLast = WDT_CYCLES - WDT_CNT_W'(1);

    logic [WDT_CNT_W-1:0] cnt_q;
    logic [WDT_CNT_W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == WdtLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WDT_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_start_sequencer.sv
// Start sequencer for the RAM-to-video output stage (output pixel clock).
// Define VIDEO_SEQ_WATCHDOG_EN to add the input frame-start watchdog.
module video_start_sequencer
    import video_seq_pkg::*;
#(
    parameter int                   HOLD_CYCLES = 16,
    parameter int                   FILL_LINES  = 2,
    parameter logic [WDT_CNT_W-1:0] WDT_CYCLES  = 24'd2_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_frame_start,
    input  logic                in_line_done,
    input  logic                req_line_doubler,
    input  logic                req_add_line,
    output logic                video_reset,
    output logic                starttrigger,
    output logic                line_doubler,
    output logic                add_line,
    output logic                running,
    output logic [RESYNC_W-1:0] resync_count
);

    localparam logic [HOLD_CNT_W-1:0] HoldLast  = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [FILL_CNT_W-1:0] FillLines = FILL_CNT_W'(FILL_LINES);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be 1..255");
    end
    if (FILL_LINES < 1 || FILL_LINES > 15) begin : g_bad_fill
        $error("FILL_LINES must be 1..15");
    end
    if (WDT_CYCLES == '0) begin : g_bad_wdt
        $error("WDT_CYCLES must be non-zero");
    end

    state_e                state_q;
    state_e                state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q;
    logic [HOLD_CNT_W-1:0] hold_cnt_d;
    logic [FILL_CNT_W-1:0] fill_cnt_q;
    logic [FILL_CNT_W-1:0] fill_cnt_d;
    logic                  ld_q;
    logic                  ld_d;
    logic                  al_q;
    logic                  al_d;
    logic [RESYNC_W-1:0]   resync_q;
    logic [RESYNC_W-1:0]   resync_d;
    logic                  vrst_q;
    logic                  vrst_d;
    logic                  trig_q;
    logic                  trig_d;
    logic                  run_q;
    logic                  run_d;
    logic                  mode_chg;
    logic                  wdt_expire;

    assign mode_chg = (req_line_doubler != ld_q) || (req_add_line != al_q);

`ifdef VIDEO_SEQ_WATCHDOG_EN
    video_seq_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (in_frame_start),
        .en_i     (state_q == RUN),
        .expire_o (wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            fill_cnt_q <= '0;
            ld_q       <= 1'b0;
            al_q       <= 1'b0;
            resync_q   <= '0;
            vrst_q     <= 1'b0;
            trig_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            ld_q       <= ld_d;
            al_q       <= al_d;
            resync_q   <= resync_d;
            vrst_q     <= vrst_d;
            trig_q     <= trig_d;
            run_q      <= run_d;
        end
    end

    // Mode change beats watchdog, which beats the input frame/line pulses.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        fill_cnt_d = fill_cnt_q;
        ld_d       = ld_q;
        al_d       = al_q;
        resync_d   = resync_q;
        if (mode_chg) begin
            ld_d       = req_line_doubler;
            al_d       = req_add_line;
            state_d    = HOLD;
            hold_cnt_d = '0;
            if (state_q != HOLD) begin
                resync_d = sat_inc(resync_q);
            end
        end else if (wdt_expire) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            resync_d   = sat_inc(resync_q);
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d = WAIT_FRAME;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
                    end
                end
                WAIT_FRAME: begin
                    if (in_frame_start) begin
                        fill_cnt_d = '0;
                        state_d    = FILL;
                    end
                end
                FILL: begin
                    if (in_frame_start) begin
                        fill_cnt_d = '0;
                    end else if (in_line_done) begin
                        fill_cnt_d = fill_cnt_q + FILL_CNT_W'(1);
                        if (fill_cnt_d == FillLines) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    always_comb begin
        vrst_d = (state_d != HOLD);
        trig_d = (state_d == RUN);
        run_d  = (state_d == RUN);
    end

    assign video_reset  = vrst_q;
    assign starttrigger = trig_q;
    assign line_doubler = ld_q;
    assign add_line     = al_q;
    assign running      = run_q;
    assign resync_count = resync_q;

endmodule
